lvds_ddr_deser_s8: RTL and testbench
====================================

# lvds_ddr_deser_s8

Multi-lane 1:S serial-to-parallel receiver for source-synchronous LVDS ADC links: a data lane plus a frame-clock lane. It samples one bit per lane per `gclk` edge and assembles MSB-first S-bit words. Word alignment is set either by manual bitslip or by automatic training on the frame lane. It sits between the pad/IDDR capture stage and the sample-processing fabric; `data_out` feeds the ADC sample path directly.

## Interface
- `S`, 8: deserialization factor, bits per word (2..8).
- `D`, 2: number of lanes; lane D-1 is the frame lane.
- `FRAME_PATTERN`, 8'hF0: expected frame-lane word (low S bits used). Default is the upper half ones, lower half zeros.
- `gclk`  in  1  sole clock, one bit period per cycle; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `datain_p`  in  D  positive leg per lane.
- `datain_n`  in  D  negative leg per lane.
- `bitslip`  in  1  manual slip request; a rising edge counts as one request.
- `use_phase_detector`  in  1  1 = automatic frame-lane alignment; 0 = manual bitslip.
- `data_out`  out  S*D  lane i word at `[i*S +: S]`; first-received bit is the MSB.
- `data_valid`  out  1  one-cycle strobe when `data_out` updates.
- `locked`  out  1  frame lane matches `FRAME_PATTERN` (auto mode only).
- `debug`  out  D+4  bits:
  - `[D-1:0]` sticky differential-error flags per lane.
  - `[D+2:D]` current slip offset, mod S.
  - `[D+3]` copy of `locked`.

## Operation
- **Sampling:** each edge registers `datain_p[i]` as the bit for lane i.
  - If `datain_p[i]==datain_n[i]`, set `debug[i]`; it clears only on reset.
  - The `p` value is used anyway.
- **Assembly:** per-lane S-bit shift register, shifting left and inserting the new bit at the LSB.
- **Word counter:** wraps 0..S-1. At count S-1 (the word boundary):
  - `data_out` loads all lane words, including the bit being shifted in.
  - `data_valid` pulses.
- **Slip:** a pending slip holds the counter at its current value for one extra cycle at the next word boundary.
  - The word window moves one bit later, so the word rotates left by 1.
  - Slip offset increments mod S.
  - Multiple requests before one boundary collapse to a single slip.
- **Manual mode** (`use_phase_detector`=0): a registered rising-edge detect on `bitslip` sets the slip-pending flag. `locked` is held 0.
- **Auto mode** (`use_phase_detector`=1): `bitslip` is ignored. A state machine evaluates at each word boundary:
  - HUNT: compare the frame-lane word with `FRAME_PATTERN`. On mismatch, request a slip and go to WAIT. On match, increment the match count; after 4 consecutive matches go to LOCK.
  - WAIT: skip 2 word boundaries, then return to HUNT with the match count cleared.
  - LOCK: `locked`=1. Any mismatch: `locked`=0, request a slip, go to WAIT.
- **Mode change:** dropping `use_phase_detector` returns the FSM to HUNT and sets `locked`=0 on the next edge. The current slip offset is kept.

## Timing
- **Reset:** while `reset`=0, asynchronously clear:
  - shift registers, counter, slip offset and pending flag;
  - `data_out`=0, `data_valid`=0, `locked`=0, `debug`=0;
  - FSM to HUNT.
- **Latency:**
  - The word whose bits are sampled at edges t..t+S-1 appears on `data_out` after edge t+S.
  - `data_valid` is high for exactly that one cycle.
- **Cadence:** `data_valid` pulses every S cycles; one slip gives a single gap of S+1 cycles.
- **First word after reset release:** counter starts at 0, so the first `data_valid` comes S cycles after the first sampling edge.
- **Reset mid-word:** the partial word is discarded. No `data_valid` is issued until a full word is assembled after release.
- **Hold:** `data_out` is stable between strobes.
- **Worst-case lock time:** (S-1) slip cycles × 3 words, plus 4 matching words.

## Test plan
- **Reset:** pull `reset` low mid-word with `data_out`≠0 → all outputs 0 immediately. After release, the first `data_valid` arrives S=8 cycles after the first sampling edge.
- **Static pattern:** lane0 = 0b00000010 repeating, lane1 = 0xF0, both aligned to the counter → `data_out`=16'hF002 with `data_valid` every 8 cycles, `debug[D+2:D]`=0.
- **Manual slip:** `use_phase_detector`=0, one `bitslip` pulse → one 9-cycle gap, then `data_out`=16'hE104 and slip offset 1. Eight pulses → back to 16'hF002.
- **Auto align:** `use_phase_detector`=1, frame lane offset by 3 bits → `locked`=1 within 25 words, then `data_out`=16'hF002 steady.
- **Loss of lock:** with `locked`=1, delay both lanes by one bit → `locked`=0 at the next boundary, then relock to 16'hF002.
- **Differential error:** force `datain_n[0]`=`datain_p[0]` for 1 cycle → `debug[0]`=1 and stays 1 until reset; `data_out` still uses `p`.

Source files
------------

// File: rtl/lvds_ddr_deser_s8.sv
// Multi-lane 1:S LVDS deserializer with a frame lane used for automatic word alignment.
// Words are assembled MSB-first; alignment moves by one-bit slips at word boundaries.
module lvds_ddr_deser_s8 #(
    parameter int unsigned S             = 8,
    parameter int unsigned D             = 2,
    parameter logic [7:0]  FRAME_PATTERN = 8'hF0
) (
    input  logic             gclk,
    input  logic             reset,
    input  logic [D-1:0]     datain_p,
    input  logic [D-1:0]     datain_n,
    input  logic             bitslip,
    input  logic             use_phase_detector,
    output logic [S*D-1:0]   data_out,
    output logic             data_valid,
    output logic             locked,
    output logic [D+3:0]     debug
);

    localparam int unsigned   CW      = (S > 1) ? $clog2(S) : 1;
    localparam logic [CW-1:0] CntLast = CW'(S - 1);
    localparam logic [2:0]    OffLast = 3'(S - 1);

    typedef enum logic [1:0] {
        StHunt,
        StWait,
        StLock
    } align_st_e;

    // Capture and assembly state
    logic                  primed_q;
    logic [D-1:0]          bit_q;
    logic [D-1:0][S-2:0]   shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [D-1:0]          err_q, err_d;

    // Slip control
    logic                  bitslip_q;
    logic                  slip_pend_q, slip_pend_d;
    logic [2:0]            slip_off_q, slip_off_d;

    // Output registers
    logic [S*D-1:0]        data_q, data_d;
    logic                  valid_q;

    // Alignment FSM
    align_st_e             st_q, st_d;
    logic [1:0]            match_q, match_d;
    logic                  wait_q, wait_d;

    logic [S*D-1:0]        word_all;
    logic [S-1:0]          frame_word;
    logic                  frame_ok;
    logic                  boundary;
    logic                  stall;
    logic                  word_done;
    logic                  man_slip;
    logic                  fsm_slip;

    // Each lane word is the S-1 stored bits plus the bit captured last cycle.
    always_comb begin
        word_all = '0;
        shift_d  = shift_q;
        for (int i = 0; i < D; i++) begin
            word_all[i*S +: S] = {shift_q[i], bit_q[i]};
            shift_d[i]         = word_all[i*S +: S-1];
        end
    end

    assign frame_word = word_all[(D-1)*S +: S];
    assign frame_ok   = (frame_word == FRAME_PATTERN[S-1:0]);

    // primed_q keeps the counter idle until the first real sample reaches the shifter.
    assign boundary   = primed_q && (cnt_q == CntLast);
    assign stall      = boundary && slip_pend_q;
    assign word_done  = boundary && !slip_pend_q;
    assign man_slip   = !use_phase_detector && bitslip && !bitslip_q;

    always_comb begin
        cnt_d = cnt_q;
        if (primed_q && !stall) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CW'(1);
        end

        slip_off_d = slip_off_q;
        if (stall) begin
            slip_off_d = (slip_off_q == OffLast) ? 3'd0 : slip_off_q + 3'd1;
        end

        // Requests arriving before the boundary collapse into the single pending flag.
        slip_pend_d = (slip_pend_q && !stall) || fsm_slip || man_slip;

        err_d  = err_q | ~(datain_p ^ datain_n);
        data_d = word_done ? word_all : data_q;
    end

    always_ff @(posedge gclk or negedge reset) begin
        if (!reset) begin
            primed_q    <= 1'b0;
            bit_q       <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            err_q       <= '0;
            bitslip_q   <= 1'b0;
            slip_pend_q <= 1'b0;
            slip_off_q  <= 3'd0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            primed_q    <= 1'b1;
            bit_q       <= datain_p;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            bitslip_q   <= bitslip;
            slip_pend_q <= slip_pend_d;
            slip_off_q  <= slip_off_d;
            data_q      <= data_d;
            valid_q     <= word_done;
        end
    end

    always_comb begin
        st_d     = st_q;
        match_d  = match_q;
        wait_d   = wait_q;
        fsm_slip = 1'b0;

        if (!use_phase_detector) begin
            st_d    = StHunt;
            match_d = 2'd0;
            wait_d  = 1'b0;
        end else if (word_done) begin
            case (st_q)
                StHunt: begin
                    if (frame_ok) begin
                        if (match_q == 2'd3) begin
                            st_d    = StLock;
                            match_d = 2'd0;
                        end else begin
                            match_d = match_q + 2'd1;
                        end
                    end else begin
                        fsm_slip = 1'b1;
                        st_d     = StWait;
                        match_d  = 2'd0;
                        wait_d   = 1'b0;
                    end
                end
                StWait: begin
                    // Let the slipped window settle for two words before judging it.
                    if (wait_q) begin
                        st_d    = StHunt;
                        match_d = 2'd0;
                        wait_d  = 1'b0;
                    end else begin
                        wait_d = 1'b1;
                    end
                end
                StLock: begin
                    if (!frame_ok) begin
                        fsm_slip = 1'b1;
                        st_d     = StWait;
                        wait_d   = 1'b0;
                    end
                end
                default: begin
                    st_d    = StHunt;
                    match_d = 2'd0;
                    wait_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge gclk or negedge reset) begin
        if (!reset) begin
            st_q    <= StHunt;
            match_q <= 2'd0;
            wait_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            match_q <= match_d;
            wait_q  <= wait_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign locked     = (st_q == StLock);
    assign debug      = {locked, slip_off_q, err_q};

endmodule

// File: tb/tb_lvds_ddr_deser_s8.sv
// Bench for lvds_ddr_deser_s8: every strobed word is checked against the last S bits driven,
// plus directed checks of reset, cadence, manual slips, auto lock and sticky error flags.
module tb_lvds_ddr_deser_s8;

    localparam int S = 8;
    localparam int D = 2;

    logic             gclk = 1'b0;
    logic             reset = 1'b0;
    logic [D-1:0]     datain_p = '0;
    logic [D-1:0]     datain_n = '1;
    logic             bitslip = 1'b0;
    logic             use_pd = 1'b0;
    logic [S*D-1:0]   data_out;
    logic             data_valid;
    logic             locked;
    logic [D+3:0]     debug;

    lvds_ddr_deser_s8 #(
        .S             (S),
        .D             (D),
        .FRAME_PATTERN (8'hF0)
    ) dut (
        .gclk               (gclk),
        .reset              (reset),
        .datain_p           (datain_p),
        .datain_n           (datain_n),
        .bitslip            (bitslip),
        .use_phase_detector (use_pd),
        .data_out           (data_out),
        .data_valid         (data_valid),
        .locked             (locked),
        .debug              (debug)
    );

    always #5 gclk = ~gclk;

    int           n_checks = 0;
    int           n_pass = 0;
    int           n_fail = 0;
    logic [D-1:0] hist[$];
    int           n = 0;
    int           g = 0;
    int           phase = 0;
    int           last_strobe = -1;
    int           strobe_cnt = 0;
    int           ph = 0;
    int           k = 0;
    bit           rand0 = 0;
    bit           slip_expect = 0;
    bit           loose_gap = 0;
    bit           strobe_seen = 0;
    logic [7:0]   fp = 8'hF0;
    logic [7:0]   p0 = 8'h02;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit per lane, clock once, then check any strobed word against the history.
    task automatic cycle(input logic bs = 1'b0, input logic err0 = 1'b0);
        int             idx;
        logic [D-1:0]   b;
        logic [D-1:0]   hb;
        logic [S*D-1:0] expw;
        idx  = (g + 8 * S - phase) % S;
        b[1] = fp[S-1-idx];
        b[0] = rand0 ? 1'($urandom % 2) : p0[S-1-idx];
        datain_p = b;
        datain_n = ~b;
        if (err0) datain_n[0] = b[0];
        bitslip = bs;
        hist.push_back(b);
        g++;
        @(posedge gclk);
        #1;
        n++;
        strobe_seen = (data_valid === 1'b1);
        if (strobe_seen) begin
            expw = 'x;
            if (n - 1 >= S) begin
                for (int j = 0; j < S; j++) begin
                    hb = hist[n-1-S+j];
                    for (int l = 0; l < D; l++) expw[l*S + S-1-j] = hb[l];
                end
            end
            chk("word", 32'(data_out), 32'(expw));
            if (last_strobe < 0) chk("first_strobe_edge", n - 1, S);
            else if (loose_gap)
                chk("gap_loose", ((n - 1 - last_strobe) == S) || ((n - 1 - last_strobe) == S + 1), 1);
            else chk("gap", n - 1 - last_strobe, slip_expect ? S + 1 : S);
            last_strobe = n - 1;
            strobe_cnt++;
            slip_expect = 0;
        end
    endtask

    task automatic wait_strobe(input string tag);
        int c;
        c = 0;
        do begin
            cycle();
            c++;
        end while (!strobe_seen && c < 2 * S + 2);
        chk(tag, strobe_seen, 1);
    endtask

    task automatic release_rst(input int phs, input logic pd);
        hist.delete();
        n = 0;
        g = 0;
        phase = phs;
        last_strobe = -1;
        strobe_cnt = 0;
        slip_expect = 0;
        use_pd = pd;
        loose_gap = pd;
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge gclk);
        #1;
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_debug", 32'(debug), 0);
        release_rst(0, 1'b0);

        // Static aligned pattern
        repeat (4) begin
            wait_strobe("static_strobe");
            chk("static_word", 32'(data_out), 32'h0000_F002);
        end
        chk("static_offset", debug[D+2:D], 0);
        cycle();
        chk("hold_between_strobes", 32'(data_out), 32'h0000_F002);

        // Differential error on lane 0 for one cycle
        cycle(1'b0, 1'b1);
        chk("diff_flag_set", debug[0], 1);
        chk("diff_flag_lane1", debug[1], 0);
        wait_strobe("diff_strobe");
        chk("diff_word_uses_p", 32'(data_out), 32'h0000_F002);
        rand0 = 1;
        repeat (6) wait_strobe("rand_strobe");
        rand0 = 0;
        chk("diff_flag_sticky", debug[0], 1);
        wait_strobe("rand_tail");

        // Manual slip: one pulse, then seven more back to the start
        wait_strobe("pre_slip");
        slip_expect = 1;
        cycle(1'b1);
        wait_strobe("slip1_strobe");
        chk("slip1_word", 32'(data_out), 32'h0000_E104);
        chk("slip1_offset", debug[D+2:D], 1);
        repeat (7) begin
            slip_expect = 1;
            cycle(1'b1);
            wait_strobe("slip_more_strobe");
        end
        chk("slip8_word", 32'(data_out), 32'h0000_F002);
        chk("slip8_offset", debug[D+2:D], 0);

        // Two requests inside one word collapse into a single slip
        slip_expect = 1;
        cycle(1'b1);
        cycle(1'b0);
        cycle(1'b1);
        wait_strobe("collapse_strobe");
        wait_strobe("collapse_next");
        chk("collapse_word", 32'(data_out), 32'h0000_E104);
        chk("collapse_offset", debug[D+2:D], 1);

        // Reset mid-word with non-zero outputs
        repeat (3) cycle();
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_data_out", 32'(data_out), 0);
        chk("midrst_valid", data_valid, 0);
        chk("midrst_debug", 32'(debug), 0);
        @(posedge gclk);
        #1;
        chk("midrst_hold", 32'(data_out), 0);
        release_rst(0, 1'b0);
        wait_strobe("post_rst_strobe");
        chk("post_rst_word", 32'(data_out), 32'h0000_F002);

        // Auto alignment from a random bit offset
        ph = int'($urandom_range(7, 1));
        #2;
        reset = 1'b0;
        @(posedge gclk);
        #1;
        release_rst(ph, 1'b1);
        k = 0;
        while (locked !== 1'b1 && k < 25 * (S + 1) + S) begin
            cycle();
            k++;
        end
        chk("auto_locked", locked, 1);
        chk("auto_words_le_25", strobe_cnt <= 25, 1);
        chk("auto_offset", debug[D+2:D], ph % S);
        chk("auto_debug_locked", debug[D+3], 1);
        loose_gap = 0;
        repeat (3) begin
            wait_strobe("lock_strobe");
            chk("lock_word", 32'(data_out), 32'h0000_F002);
        end

        // bitslip has no effect in auto mode
        cycle(1'b1);
        wait_strobe("auto_bitslip_strobe");
        chk("auto_bitslip_offset", debug[D+2:D], ph % S);
        chk("auto_bitslip_locked", locked, 1);

        // Loss of lock: delay both lanes by one bit
        wait_strobe("lol_pre");
        phase = phase + 1;
        loose_gap = 1;
        wait_strobe("lol_strobe");
        chk("lol_unlocked", locked, 0);
        strobe_cnt = 0;
        k = 0;
        while (locked !== 1'b1 && k < 25 * (S + 1) + S) begin
            cycle();
            k++;
        end
        chk("relock", locked, 1);
        chk("relock_words_le_25", strobe_cnt <= 25, 1);
        chk("relock_offset", debug[D+2:D], (ph + 1) % S);
        loose_gap = 0;
        repeat (2) begin
            wait_strobe("relock_strobe");
            chk("relock_word", 32'(data_out), 32'h0000_F002);
        end

        // Dropping auto mode clears lock but keeps the offset
        use_pd = 1'b0;
        cycle();
        chk("mode_drop_locked", locked, 0);
        chk("mode_drop_debug_locked", debug[D+3], 0);
        chk("mode_drop_offset", debug[D+2:D], (ph + 1) % S);
        wait_strobe("mode_drop_strobe");
        chk("mode_drop_word", 32'(data_out), 32'h0000_F002);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
